// File: rtl/lgu_pkg.sv
// Shared types and constants for the logic gate unit.
package lgu_pkg;

  localparam int unsigned LGU_OP_W         = 3;
  localparam int unsigned LGU_CNT_W        = 16;
  localparam int unsigned LGU_MAX_CHANNELS = 8;

  typedef enum logic [LGU_OP_W-1:0] {
    LGU_OP_AND  = 3'd0,
    LGU_OP_OR   = 3'd1,
    LGU_OP_XOR  = 3'd2,
    LGU_OP_NAND = 3'd3,
    LGU_OP_NOR  = 3'd4,
    LGU_OP_XNOR = 3'd5,
    LGU_OP_PASS = 3'd6,
    LGU_OP_RSVD = 3'd7
  } lgu_op_t;

  // Output register occupancy; FULL means out_valid is high.
  typedef enum logic {
    LGU_ST_EMPTY = 1'b0,
    LGU_ST_FULL  = 1'b1
  } lgu_state_t;

endpackage

// File: rtl/lgu_reduce.sv
// Combinational bitwise reduction of CHANNELS operands under one gate op.
module lgu_reduce
  import lgu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic [LGU_OP_W-1:0]       op_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]          result_c,
  output logic                      err_c
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  lgu_op_t          op;

  assign op = lgu_op_t'(op_i);

  // Inverted ops invert the full reduction, never a pairwise chain.
  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      and_r = and_r & data_i[k*WIDTH +: WIDTH];
      or_r  = or_r  | data_i[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ data_i[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result_c = '0;
    err_c    = 1'b0;
    case (op)
      LGU_OP_AND:  result_c = and_r;
      LGU_OP_OR:   result_c = or_r;
      LGU_OP_XOR:  result_c = xor_r;
      LGU_OP_NAND: result_c = ~and_r;
      LGU_OP_NOR:  result_c = ~or_r;
      LGU_OP_XNOR: result_c = ~xor_r;
      LGU_OP_PASS: result_c = data_i[WIDTH-1:0];
      default:     err_c    = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered multi-operand gate with a one-deep valid/ready output stage.
// Optional LGU_TXN_COUNT_EN adds a saturating count of consumed results.
module logic_gate_unit
  import lgu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LGU_OP_W-1:0]       in_op,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_zero,
  output logic                      out_err
`ifdef LGU_TXN_COUNT_EN
  ,
  output logic [LGU_CNT_W-1:0]      txn_count
`endif
);

  lgu_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_c;
  logic             err_c;
  logic             accept_c;
  logic             consume_c;

  lgu_reduce #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_reduce (
    .op_i     (in_op),
    .data_i   (in_data),
    .result_c (result_c),
    .err_c    (err_c)
  );

  // Ready depends only on the output stage, never on in_valid.
  assign in_ready  = (state_q == LGU_ST_EMPTY) || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign consume_c = (state_q == LGU_ST_FULL) && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;
    if (accept_c) begin
      state_d = LGU_ST_FULL;
      data_d  = result_c;
      zero_d  = (result_c == '0);
      err_d   = err_c;
    end else if (consume_c) begin
      state_d = LGU_ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LGU_ST_EMPTY;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == LGU_ST_FULL);
  assign out_data  = data_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;

`ifdef LGU_TXN_COUNT_EN
  logic [LGU_CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of consumed results, reserved-op results included.
  always_comb begin
    cnt_d = cnt_q;
    if (consume_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + LGU_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench: a 2-channel and a 3-channel unit sharing control signals.
module tb_logic_gate_unit;

  bit         clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] in_op;
  logic [15:0] in_data2;
  logic [23:0] in_data3;
  logic       in_ready2, in_ready3;
  logic       out_valid2, out_valid3;
  logic [7:0] out_data2, out_data3;
  logic       out_zero2, out_zero3;
  logic       out_err2, out_err3;
`ifdef LGU_TXN_COUNT_EN
  logic [15:0] txn_count2, txn_count3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .CHANNELS(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready2), .in_op (in_op), .in_data (in_data2),
    .out_valid (out_valid2), .out_ready (out_ready), .out_data (out_data2),
    .out_zero (out_zero2), .out_err (out_err2)
`ifdef LGU_TXN_COUNT_EN
    , .txn_count (txn_count2)
`endif
  );

  logic_gate_unit #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready3), .in_op (in_op), .in_data (in_data3),
    .out_valid (out_valid3), .out_ready (out_ready), .out_data (out_data3),
    .out_zero (out_zero3), .out_err (out_err3)
`ifdef LGU_TXN_COUNT_EN
    , .txn_count (txn_count3)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp2 [8];
  logic [7:0] exp3 [8];

  initial begin
    exp2 = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h00};
    exp3 = '{8'h0C, 8'hFF, 8'hCC, 8'hF3, 8'h00, 8'h33, 8'hFF, 8'h00};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0;
    in_data2 = '0; in_data3 = '0;
    step(); step();
    chk("rst_valid", 16'(out_valid2), 16'h0);
    chk("rst_data", 16'(out_data2), 16'h0);
    chk("rst_zero", 16'(out_zero2), 16'h0);
    chk("rst_err", 16'(out_err2), 16'h0);
    chk("rst_in_ready", 16'(in_ready2), 16'h1);
    rst_n = 1'b1;

    // Truth table streamed one op per cycle; channel 0 in the low byte.
    in_data2 = {8'hCC, 8'hF0};
    in_data3 = {8'h3C, 8'h0F, 8'hFF};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int op = 0; op < 8; op++) begin
      in_op = 3'(op);
      step();
      chk($sformatf("tt2_valid_op%0d", op), 16'(out_valid2), 16'h1);
      chk($sformatf("tt2_data_op%0d", op), 16'(out_data2), 16'(exp2[op]));
      chk($sformatf("tt2_err_op%0d", op), 16'(out_err2), (op == 7) ? 16'h1 : 16'h0);
      chk($sformatf("tt2_zero_op%0d", op), 16'(out_zero2), (op == 7) ? 16'h1 : 16'h0);
      chk($sformatf("tt3_data_op%0d", op), 16'(out_data3), 16'(exp3[op]));
      chk($sformatf("tt3_zero_op%0d", op), 16'(out_zero3), (exp3[op] == 8'h00) ? 16'h1 : 16'h0);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 16'(out_valid2), 16'h0);
    chk("drain_hold_data", 16'(out_data2), 16'h00);
    chk("drain_hold_err", 16'(out_err2), 16'h1);
    chk("drain_hold_err3", 16'(out_err3), 16'h1);

    // Backpressure: result held while inputs wander.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 3'd0;
    in_data2 = {8'hFF, 8'hAA};
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_valid_%0d", i), 16'(out_valid2), 16'h1);
      chk($sformatf("bp_data_%0d", i), 16'(out_data2), 16'h00AA);
      chk($sformatf("bp_in_ready_%0d", i), 16'(in_ready2), 16'h0);
      chk($sformatf("bp_in_ready3_%0d", i), 16'(in_ready3), 16'h0);
      in_op = 3'(i + 1);
      in_data2 = {8'(i), 8'(8'h10 + i)};
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(in_ready2), 16'h1);
    step();
    chk("bp_one_consume", 16'(out_valid2), 16'h0);
    chk("bp_data_held", 16'(out_data2), 16'h00AA);
    step();
    chk("bp_still_empty", 16'(out_valid2), 16'h0);

    // Streaming PASS results at full throughput.
    in_valid = 1'b1;
    in_op = 3'd6;
    for (int i = 0; i < 10; i++) begin
      in_data2 = {8'h00, 8'(i + 1)};
      step();
      chk($sformatf("stream_valid_%0d", i), 16'(out_valid2), 16'h1);
      chk($sformatf("stream_data_%0d", i), 16'(out_data2), 16'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", 16'(out_valid2), 16'h0);

    // Reset asserted between edges drops a held result at once.
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data2 = {8'h00, 8'h55};
    step();
    chk("mid_pre_valid", 16'(out_valid2), 16'h1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(out_valid2), 16'h0);
    chk("mid_rst_data", 16'(out_data2), 16'h0);
    chk("mid_rst_zero", 16'(out_zero2), 16'h0);
    chk("mid_rst_err", 16'(out_err2), 16'h0);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data2 = {8'h00, 8'h81};
    step();
    chk("post_rst_valid", 16'(out_valid2), 16'h1);
    chk("post_rst_data", 16'(out_data2), 16'h0081);
    in_valid = 1'b0;
    step();
    chk("post_rst_drain", 16'(out_valid2), 16'h0);

`ifdef LGU_TXN_COUNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", txn_count2, 16'h0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    step();
    chk("cnt_five", txn_count2, 16'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 65529; i++) step();
    in_valid = 1'b0;
    step();
    chk("cnt_fffe", txn_count2, 16'hFFFE);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    step();
    chk("cnt_sat", txn_count2, 16'hFFFF);
    step(); step();
    chk("cnt_sat_hold", txn_count2, 16'hFFFF);
    chk("cnt_sat_dut3", txn_count3, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, registered successor to the single-bit two-input gate cells.
- Applies one runtime-selectable bitwise gate function across CHANNELS operands of WIDTH bits each.
- Result sits in a one-deep output register with a valid/ready handshake.
- Used wherever the library needs a multi-operand gate that sits cleanly inside a clocked pipeline.

Parameters:
WIDTH, 8, bits per operand and result
CHANNELS, 2, number of operands reduced (legal range 2..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle and op are valid this cycle
in_ready  output  1  unit can accept a bundle this cycle
in_op  input  3  gate select, sampled on accept
in_data  input  CHANNELS*WIDTH  operands; channel k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  registered result
out_zero  output  1  registered flag, out_data == 0
out_err  output  1  registered flag, the reserved op was used

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_zero=0, out_err=0.
- Reset assertion takes effect immediately, mid-transaction included; any held result is discarded.
- Op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 PASS: channel 0 unchanged.
  - 7 reserved: result forced to 0, out_err=1.
- Reduction: bitwise across all CHANNELS. NAND, NOR and XNOR are the inversions of the full AND, OR and XOR reductions. They are not chained pairwise.
- Width rule: result is exactly WIDTH bits; there is no carry or growth.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and there is no in_valid-to-in_ready path.
  - Accept = in_valid && in_ready.
  - On accept, out_data, out_zero and out_err load on the same edge and out_valid is set. Latency is 1 cycle.
  - A result is consumed when out_valid && out_ready.
  - Consume without accept clears out_valid. Data/flag registers hold their last values.
  - Simultaneous consume and accept: the new result loads and out_valid stays 1, giving full throughput of one result per cycle.
  - out_valid=1 and out_ready=0: in_ready=0, and out_data/out_zero/out_err are held stable until consumed.
- Inputs are ignored whenever no accept occurs, including in_op changes while stalled.
- States (implicit in out_valid):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on consume with accept, or on stall.

Optional Feature:
- Macro: LGU_TXN_COUNT_EN.
- Defined:
  - Adds output port txn_count, 16 bits: the number of consumed results.
  - Reset to 0 and saturates at 16'hFFFF (no wrap).
  - Increments one cycle after each consume.
  - Results with out_err=1 are counted as well.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lgu_pkg holds:
  - the 3-bit op typedef lgu_op_t;
  - named constants LGU_OP_AND..LGU_OP_RSVD;
  - LGU_MAX_CHANNELS = 8.
- Sub-module lgu_reduce: purely combinational.
  - Takes WIDTH, CHANNELS, op and the flattened data.
  - Returns the result and err.
  - The top owns all registers and the handshake.

Test Plan:
- Reset mid-stream: hold out_valid=1, pulse rst_n low between clock edges -> out_valid drops immediately without waiting for an edge, all outputs 0, and the next accept works normally.
- Truth table (WIDTH=8, CHANNELS=2, operands 8'hF0, 8'hCC), one cycle later:
  - AND -> 8'hC0; OR -> 8'hFC; XOR -> 8'h3C.
  - NAND -> 8'h3F; NOR -> 8'h03; XNOR -> 8'hC3.
  - PASS -> 8'hF0; reserved op -> 8'h00 with out_zero=1 and out_err=1.
- Three-channel reduction (CHANNELS=3, operands 8'hFF, 8'h0F, 8'h3C):
  - AND -> 8'h0C; XOR -> 8'hCC; NAND -> 8'hF3.
  - Proves inversion is applied after the full reduction.
- Backpressure: accept AND(8'hAA, 8'hFF), hold out_ready=0 for 4 cycles while changing in_data/in_op -> out_data stays 8'hAA and in_ready stays 0 throughout; release -> exactly one consume.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with an incrementing operand -> 10 results in order at 1 per cycle, no bubbles, no duplicates.
- LGU_TXN_COUNT_EN:
  - 5 consumes -> txn_count = 5.
  - Preload near 16'hFFFE via a long run, then 3 more consumes -> txn_count = 16'hFFFF, held (saturates).
